// File: rtl/ftm_trigger_ctrl.sv
// Fabric-side FTM trigger controller: queued F2P 4-phase handshakes
// with phase timeout, and P2F trigger to valid/ready conversion.
module ftm_trigger_ctrl #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int PEND_W         = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          trig_req,
  output logic [3:0]          f2p_busy,
  output logic [4*PEND_W-1:0] f2p_pending,
  output logic [3:0]          F2PTRIG,
  input  logic [3:0]          F2PTRIGACK,
  input  logic [3:0]          P2FTRIG,
  output logic [3:0]          P2FTRIGACK,
  output logic [3:0]          p2f_valid,
  input  logic [3:0]          p2f_ready,
  input  logic                err_clr,
  output logic [3:0]          f2p_timeout,
  output logic [3:0]          f2p_overflow
);

  typedef enum logic [1:0] {
    F_IDLE, F_ASSERT, F_RELEASE
  } f_state_e;

  typedef enum logic [1:0] {
    P_WAIT_HI, P_OFFER, P_ACKED
  } p_state_e;

  localparam int TW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TLIM =
    TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [PEND_W-1:0] PMAX = '1;

  logic [SYNC_STAGES-1:0][3:0] ack_sq;
  logic [SYNC_STAGES-1:0][3:0] trg_sq;
  logic [3:0] ack_s;
  logic [3:0] trg_s;

  always_ff @(posedge clk) begin
    if (rst) begin
      ack_sq <= '0;
      trg_sq <= '0;
    end else begin
      ack_sq <= {ack_sq[SYNC_STAGES-2:0], F2PTRIGACK};
      trg_sq <= {trg_sq[SYNC_STAGES-2:0], P2FTRIG};
    end
  end

  assign ack_s = ack_sq[SYNC_STAGES-1];
  assign trg_s = trg_sq[SYNC_STAGES-1];

  for (genvar n = 0; n < 4; n++) begin : g_ch
    f_state_e          fst_q;
    p_state_e          pst_q;
    logic [TW-1:0]     tmr_q;
    logic [PEND_W-1:0] pend_q;
    logic [PEND_W-1:0] pend_d;
    logic              go;
    logic              ovf;
    logic              tmo;
    logic              trig_q;
    logic              to_q;
    logic              ov_q;
    logic              val_q;
    logic              pack_q;

    // A request in IDLE launches directly; it never touches the queue.
    always_comb begin
      go     = (fst_q == F_IDLE) && ((pend_q != '0) || trig_req[n]);
      ovf    = trig_req[n] && !go && (pend_q == PMAX);
      tmo    = TO_EN && (tmr_q == TLIM);
      pend_d = pend_q;
      if (trig_req[n] && !go && !ovf)
        pend_d = pend_q + 1'b1;
      else if (!trig_req[n] && go)
        pend_d = pend_q - 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        fst_q  <= F_IDLE;
        tmr_q  <= '0;
        pend_q <= '0;
        trig_q <= 1'b0;
        to_q   <= 1'b0;
        ov_q   <= 1'b0;
      end else begin
        pend_q <= pend_d;
        if (err_clr) begin
          to_q <= 1'b0;
          ov_q <= 1'b0;
        end
        if (ovf)
          ov_q <= 1'b1;
        unique case (fst_q)
          F_IDLE: begin
            if (go) begin
              fst_q  <= F_ASSERT;
              tmr_q  <= '0;
              trig_q <= 1'b1;
            end
          end
          F_ASSERT: begin
            if (ack_s[n] || tmo) begin
              fst_q  <= F_RELEASE;
              tmr_q  <= '0;
              trig_q <= 1'b0;
              if (!ack_s[n])
                to_q <= 1'b1;
            end else begin
              tmr_q <= tmr_q + 1'b1;
            end
          end
          F_RELEASE: begin
            if (!ack_s[n] || tmo) begin
              fst_q <= F_IDLE;
              if (ack_s[n])
                to_q <= 1'b1;
            end else begin
              tmr_q <= tmr_q + 1'b1;
            end
          end
          default: begin
            fst_q  <= F_IDLE;
            trig_q <= 1'b0;
          end
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        pst_q  <= P_WAIT_HI;
        val_q  <= 1'b0;
        pack_q <= 1'b0;
      end else begin
        unique case (pst_q)
          P_WAIT_HI: begin
            if (trg_s[n]) begin
              pst_q <= P_OFFER;
              val_q <= 1'b1;
            end
          end
          P_OFFER: begin
            if (p2f_ready[n]) begin
              pst_q  <= P_ACKED;
              val_q  <= 1'b0;
              pack_q <= 1'b1;
            end
          end
          P_ACKED: begin
            if (!trg_s[n]) begin
              pst_q  <= P_WAIT_HI;
              pack_q <= 1'b0;
            end
          end
          default: begin
            pst_q  <= P_WAIT_HI;
            val_q  <= 1'b0;
            pack_q <= 1'b0;
          end
        endcase
      end
    end

    assign F2PTRIG[n]      = trig_q;
    assign f2p_timeout[n]  = to_q;
    assign f2p_overflow[n] = ov_q;
    assign f2p_busy[n]     = (fst_q != F_IDLE) || (pend_q != '0);
    assign p2f_valid[n]    = val_q;
    assign P2FTRIGACK[n]   = pack_q;
    assign f2p_pending[n*PEND_W +: PEND_W] = pend_q;
  end

endmodule

// File: tb/tb_ftm_trigger_ctrl.sv
// Directed bench for ftm_trigger_ctrl with a delayed-ack ECT model
// (ack follows F2PTRIG by three cycles when enabled).
module tb_ftm_trigger_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  trig_req;
  logic [3:0]  f2p_busy;
  logic [15:0] f2p_pending;
  logic [3:0]  F2PTRIG;
  logic [3:0]  P2FTRIG;
  logic [3:0]  P2FTRIGACK;
  logic [3:0]  p2f_valid;
  logic [3:0]  p2f_ready;
  logic        err_clr;
  logic [3:0]  f2p_timeout;
  logic [3:0]  f2p_overflow;

  logic [3:0] bfm_en = '0;
  logic [3:0] d1 = '0;
  logic [3:0] d2 = '0;
  logic [3:0] d3 = '0;
  logic [3:0] f_prev = '0;
  logic [3:0] v_prev = '0;
  int f_cnt [4];
  int v_cnt [4];
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ftm_trigger_ctrl #(
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(16),
    .PEND_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .trig_req(trig_req),
    .f2p_busy(f2p_busy),
    .f2p_pending(f2p_pending),
    .F2PTRIG(F2PTRIG),
    .F2PTRIGACK(d3),
    .P2FTRIG(P2FTRIG),
    .P2FTRIGACK(P2FTRIGACK),
    .p2f_valid(p2f_valid),
    .p2f_ready(p2f_ready),
    .err_clr(err_clr),
    .f2p_timeout(f2p_timeout),
    .f2p_overflow(f2p_overflow)
  );

  always @(posedge clk) begin
    d1 <= F2PTRIG & bfm_en;
    d2 <= d1;
    d3 <= d2;
    for (int n = 0; n < 4; n++) begin
      if (F2PTRIG[n] && !f_prev[n]) f_cnt[n] <= f_cnt[n] + 1;
      if (p2f_valid[n] && !v_prev[n]) v_cnt[n] <= v_cnt[n] + 1;
    end
    f_prev <= F2PTRIG;
    v_prev <= p2f_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (F2PTRIG !== 4'h0) begin
      n_bad++; $display("FAIL reset_trig got %h want 0", F2PTRIG);
    end
    n_cmp++;
    if (P2FTRIGACK !== 4'h0) begin
      n_bad++; $display("FAIL reset_pack got %h want 0", P2FTRIGACK);
    end
    n_cmp++;
    if (p2f_valid !== 4'h0) begin
      n_bad++; $display("FAIL reset_valid got %h want 0", p2f_valid);
    end
    n_cmp++;
    if (f2p_busy !== 4'h0) begin
      n_bad++; $display("FAIL reset_busy got %h want 0", f2p_busy);
    end
    n_cmp++;
    if (f2p_pending !== 16'h0) begin
      n_bad++; $display("FAIL reset_pend got %h want 0", f2p_pending);
    end
    n_cmp++;
    if ({f2p_timeout, f2p_overflow} !== 8'h0) begin
      n_bad++;
      $display("FAIL reset_err got %h want 0", {f2p_timeout, f2p_overflow});
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    int c0;
    bfm_en[0] = 1'b1;
    c0 = f_cnt[0];
    tick();
    trig_req = 4'b0001;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 1) trig_req = 4'h0;
      n_cmp++;
      if (F2PTRIG[0] !== (i <= 6)) begin
        n_bad++;
        $display("FAIL single_trig c%0d got %b want %b", i, F2PTRIG[0], i <= 6);
      end
      n_cmp++;
      if (f2p_busy[0] !== (i <= 12)) begin
        n_bad++;
        $display("FAIL single_busy c%0d got %b want %b", i, f2p_busy[0], i <= 12);
      end
      n_cmp++;
      if (f2p_pending[3:0] !== 4'h0) begin
        n_bad++;
        $display("FAIL single_pend c%0d got %h want 0", i, f2p_pending[3:0]);
      end
    end
    repeat (2) tick();
    n_cmp++;
    if (f_cnt[0] - c0 !== 1) begin
      n_bad++; $display("FAIL single_count got %0d want 1", f_cnt[0] - c0);
    end
  endtask

  task automatic test_queue();
    int c1;
    int k;
    bfm_en[1] = 1'b0;
    c1 = f_cnt[1];
    tick();
    trig_req = 4'b0010;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 1) begin
        n_cmp++;
        if (F2PTRIG[1] !== 1'b1 || f2p_pending[7:4] !== 4'h0) begin
          n_bad++;
          $display("FAIL queue_first got trig %b pend %h want 1/0",
                   F2PTRIG[1], f2p_pending[7:4]);
        end
      end
      if (i == 16) begin
        n_cmp++;
        if (f2p_pending[7:4] !== 4'hF || f2p_overflow[1] !== 1'b0) begin
          n_bad++;
          $display("FAIL queue_sat got pend %h ovf %b want f/0",
                   f2p_pending[7:4], f2p_overflow[1]);
        end
        err_clr = 1'b1;
      end
      if (i == 17) begin
        trig_req  = 4'h0;
        err_clr   = 1'b0;
        bfm_en[1] = 1'b1;
        n_cmp++;
        if (f2p_pending[7:4] !== 4'hF) begin
          n_bad++; $display("FAIL queue_hold got %h want f", f2p_pending[7:4]);
        end
        n_cmp++;
        if (f2p_overflow[1] !== 1'b1 || f2p_timeout[1] !== 1'b1) begin
          n_bad++;
          $display("FAIL queue_setwins got ovf %b to %b want 1/1",
                   f2p_overflow[1], f2p_timeout[1]);
        end
        n_cmp++;
        if (F2PTRIG[1] !== 1'b0) begin
          n_bad++; $display("FAIL queue_tmo_drop got %b want 0", F2PTRIG[1]);
        end
      end
    end
    k = 0;
    while (f2p_busy[1] && k < 2000) begin
      tick();
      k++;
    end
    n_cmp++;
    if (f2p_busy[1] !== 1'b0) begin
      n_bad++; $display("FAIL queue_drain got busy %b want 0", f2p_busy[1]);
    end
    repeat (2) tick();
    n_cmp++;
    if (f_cnt[1] - c1 !== 16) begin
      n_bad++; $display("FAIL queue_count got %0d want 16", f_cnt[1] - c1);
    end
    n_cmp++;
    if (f2p_overflow[1] !== 1'b1) begin
      n_bad++; $display("FAIL queue_sticky got %b want 1", f2p_overflow[1]);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_cmp++;
    if (f2p_overflow !== 4'h0 || f2p_timeout !== 4'h0) begin
      n_bad++;
      $display("FAIL queue_errclr got ovf %h to %h want 0/0",
               f2p_overflow, f2p_timeout);
    end
  endtask

  task automatic test_timeout();
    int c2;
    bfm_en[2] = 1'b0;
    tick();
    trig_req = 4'b0100;
    for (int i = 1; i <= 18; i++) begin
      tick();
      if (i == 1) trig_req = 4'h0;
      n_cmp++;
      if (F2PTRIG[2] !== (i <= 16)) begin
        n_bad++;
        $display("FAIL tmo_trig c%0d got %b want %b", i, F2PTRIG[2], i <= 16);
      end
      if (i == 16) begin
        n_cmp++;
        if (f2p_timeout[2] !== 1'b0) begin
          n_bad++; $display("FAIL tmo_early got %b want 0", f2p_timeout[2]);
        end
      end
      if (i == 17) begin
        n_cmp++;
        if (f2p_timeout[2] !== 1'b1 || f2p_busy[2] !== 1'b1) begin
          n_bad++;
          $display("FAIL tmo_set got to %b busy %b want 1/1",
                   f2p_timeout[2], f2p_busy[2]);
        end
      end
      if (i == 18) begin
        n_cmp++;
        if (f2p_busy[2] !== 1'b0) begin
          n_bad++; $display("FAIL tmo_idle got %b want 0", f2p_busy[2]);
        end
      end
    end
    bfm_en[2] = 1'b1;
    c2 = f_cnt[2];
    tick();
    trig_req = 4'b0100;
    for (int i = 1; i <= 14; i++) begin
      tick();
      if (i == 1) trig_req = 4'h0;
      n_cmp++;
      if (F2PTRIG[2] !== (i <= 6)) begin
        n_bad++;
        $display("FAIL tmo_retry c%0d got %b want %b", i, F2PTRIG[2], i <= 6);
      end
    end
    repeat (2) tick();
    n_cmp++;
    if (f_cnt[2] - c2 !== 1 || f2p_timeout[2] !== 1'b1) begin
      n_bad++;
      $display("FAIL tmo_after got cnt %0d to %b want 1/1",
               f_cnt[2] - c2, f2p_timeout[2]);
    end
  endtask

  task automatic test_p2f_backpressure();
    int cv;
    p2f_ready = 4'h0;
    cv = v_cnt[3];
    tick();
    P2FTRIG = 4'b1000;
    for (int i = 1; i <= 22; i++) begin
      tick();
      if (i == 12) p2f_ready[3] = 1'b1;
      if (i == 13) p2f_ready[3] = 1'b0;
      if (i == 15) P2FTRIG[3] = 1'b0;
      n_cmp++;
      if (p2f_valid[3] !== (i >= 3 && i <= 12)) begin
        n_bad++;
        $display("FAIL bp_valid c%0d got %b want %b", i, p2f_valid[3],
                 i >= 3 && i <= 12);
      end
      n_cmp++;
      if (P2FTRIGACK[3] !== (i >= 13 && i <= 17)) begin
        n_bad++;
        $display("FAIL bp_ack c%0d got %b want %b", i, P2FTRIGACK[3],
                 i >= 13 && i <= 17);
      end
    end
    n_cmp++;
    if (v_cnt[3] - cv !== 1) begin
      n_bad++; $display("FAIL bp_events got %0d want 1", v_cnt[3] - cv);
    end
  endtask

  task automatic test_reset_mid();
    bfm_en[0] = 1'b0;
    p2f_ready = 4'h0;
    tick();
    trig_req = 4'b0001;
    P2FTRIG  = 4'b1000;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 6) trig_req = 4'h0;
    end
    n_cmp++;
    if (f2p_pending[3:0] !== 4'h5 || F2PTRIG[0] !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_pre got pend %h trig %b want 5/1",
               f2p_pending[3:0], F2PTRIG[0]);
    end
    n_cmp++;
    if (f2p_timeout !== 4'b0100 || p2f_valid[3] !== 1'b1) begin
      n_bad++;
      $display("FAIL rmid_pre2 got to %h valid %b want 4/1",
               f2p_timeout, p2f_valid[3]);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if (F2PTRIG !== 4'h0 || f2p_pending !== 16'h0 || f2p_busy !== 4'h0) begin
      n_bad++;
      $display("FAIL rmid_f2p got trig %h pend %h busy %h want 0",
               F2PTRIG, f2p_pending, f2p_busy);
    end
    n_cmp++;
    if (f2p_timeout !== 4'h0 || f2p_overflow !== 4'h0) begin
      n_bad++;
      $display("FAIL rmid_err got to %h ovf %h want 0",
               f2p_timeout, f2p_overflow);
    end
    n_cmp++;
    if (p2f_valid !== 4'h0 || P2FTRIGACK !== 4'h0) begin
      n_bad++;
      $display("FAIL rmid_p2f got valid %h ack %h want 0",
               p2f_valid, P2FTRIGACK);
    end
    rst = 1'b0;
    for (int i = 8; i <= 10; i++) begin
      tick();
      if (i == 9) begin
        n_cmp++;
        if (p2f_valid[3] !== 1'b0) begin
          n_bad++; $display("FAIL rmid_sync got %b want 0", p2f_valid[3]);
        end
      end
      if (i == 10) begin
        n_cmp++;
        if (p2f_valid[3] !== 1'b1) begin
          n_bad++; $display("FAIL rmid_reoffer got %b want 1", p2f_valid[3]);
        end
      end
    end
    p2f_ready = 4'b1000;
    tick();
    p2f_ready = 4'h0;
    P2FTRIG   = 4'h0;
    repeat (5) tick();
    n_cmp++;
    if (P2FTRIGACK[3] !== 1'b0) begin
      n_bad++; $display("FAIL rmid_done got %b want 0", P2FTRIGACK[3]);
    end
  endtask

  task automatic test_concurrency();
    int cf [4];
    int cv [4];
    int k;
    int want;
    bfm_en    = 4'hF;
    p2f_ready = 4'hF;
    for (int n = 0; n < 4; n++) begin
      cf[n] = f_cnt[n];
      cv[n] = v_cnt[n];
    end
    tick();
    trig_req = 4'hF;
    P2FTRIG  = 4'hF;
    tick();
    trig_req = 4'b0101;
    n_cmp++;
    if (F2PTRIG !== 4'hF) begin
      n_bad++; $display("FAIL conc_trig got %h want f", F2PTRIG);
    end
    tick();
    trig_req = 4'h0;
    n_cmp++;
    if (f2p_pending !== 16'h0101) begin
      n_bad++; $display("FAIL conc_pend got %h want 0101", f2p_pending);
    end
    tick();
    n_cmp++;
    if (p2f_valid !== 4'hF) begin
      n_bad++; $display("FAIL conc_valid got %h want f", p2f_valid);
    end
    tick();
    P2FTRIG = 4'h0;
    n_cmp++;
    if (p2f_valid !== 4'h0 || P2FTRIGACK !== 4'hF) begin
      n_bad++;
      $display("FAIL conc_pulse got valid %h ack %h want 0/f",
               p2f_valid, P2FTRIGACK);
    end
    k = 0;
    while ((f2p_busy != 4'h0 || P2FTRIGACK != 4'h0) && k < 500) begin
      tick();
      k++;
    end
    n_cmp++;
    if (f2p_busy !== 4'h0 || P2FTRIGACK !== 4'h0) begin
      n_bad++;
      $display("FAIL conc_drain got busy %h ack %h want 0/0",
               f2p_busy, P2FTRIGACK);
    end
    repeat (2) tick();
    for (int n = 0; n < 4; n++) begin
      want = (n == 0 || n == 2) ? 2 : 1;
      n_cmp++;
      if (f_cnt[n] - cf[n] !== want) begin
        n_bad++;
        $display("FAIL conc_f2p ch%0d got %0d want %0d", n,
                 f_cnt[n] - cf[n], want);
      end
      n_cmp++;
      if (v_cnt[n] - cv[n] !== 1) begin
        n_bad++;
        $display("FAIL conc_p2f ch%0d got %0d want 1", n, v_cnt[n] - cv[n]);
      end
    end
  endtask

  initial begin
    rst       = 1'b1;
    trig_req  = 4'h0;
    P2FTRIG   = 4'h0;
    p2f_ready = 4'h0;
    err_clr   = 1'b0;
    test_reset();
    test_single();
    test_queue();
    test_timeout();
    test_p2f_backpressure();
    test_reset_mid();
    test_concurrency();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
